// File: rtl/dmem_banked_pkg.sv
// Shared types and helpers for the banked data memory: the access-length
// encoding, the FSM states, and the lane-mask and load-extension helpers.
package dmem_banked_pkg;

  typedef enum logic [1:0] {
    LEN_NONE = 2'b00,
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_WORD = 2'b11
  } memlen_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int LANES = 4;

  // Byte lanes touched by an access of length len at byte offset off.
  function automatic logic [LANES-1:0] lane_mask(memlen_e len, logic [1:0] off);
    case (len)
      LEN_BYTE: return 4'b0001 << off;
      LEN_HALF: return 4'b0011 << {off[1], 1'b0};
      LEN_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  // raw already has the addressed byte/half shifted down to bit 0.
  function automatic logic [31:0] extend(memlen_e len, logic sgn, logic [31:0] raw);
    case (len)
      LEN_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
      LEN_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
      default:  return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous write, registered read port.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM;
  // clearing it is the job of the zero-fill sweep in the top level.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_banked.sv
// Byte-addressed 32-bit data memory built from four byte-lane banks, with a
// valid/ready request port, one-cycle response, error reporting and zero-fill.
module dmem_banked
  import dmem_banked_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_len,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int WAW   = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** WAW;

  state_e         state, state_next;
  logic [WAW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    case (state)
      ST_INIT: if (&cnt) state_next = ST_RUN;
      ST_RUN:  req_ready = 1'b1;
      default: state_next = ST_INIT;
    endcase
  end

  memlen_e    len;
  logic [1:0] off;
  logic       err, accept, ok;

  assign len    = memlen_e'(req_len);
  assign off    = req_addr[1:0];
  assign accept = req_valid & req_ready;
  assign ok     = accept & ~err;

  always_comb begin
    err = |(req_addr >> ADDR_WIDTH);
    case (len)
      LEN_NONE: err = 1'b1;
      LEN_HALF: if (off[0]) err = 1'b1;
      LEN_WORD: if (off != 2'b00) err = 1'b1;
      default:  ;
    endcase
  end

  logic [LANES-1:0] bank_we;
  logic             bank_re;
  logic [WAW-1:0]   bank_addr;
  logic [31:0]      bank_wdata;
  logic [7:0]       bank_rdata [LANES];

  // During the sweep the banks are owned by the counter; afterwards by the port.
  always_comb begin
    bank_we    = '0;
    bank_re    = 1'b0;
    bank_addr  = req_addr[ADDR_WIDTH-1:2];
    bank_wdata = req_wdata;
    if (state == ST_INIT) begin
      bank_we    = '1;
      bank_addr  = cnt;
      bank_wdata = '0;
    end else begin
      bank_re = ok & ~req_we;
      if (ok && req_we) bank_we = lane_mask(len, off);
      case (len)
        LEN_BYTE: bank_wdata = {4{req_wdata[7:0]}};
        LEN_HALF: bank_wdata = {2{req_wdata[15:0]}};
        default:  bank_wdata = req_wdata;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    dmem_bank #(.DEPTH(WORDS), .AW(WAW)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[g]),
      .re    (bank_re),
      .addr  (bank_addr),
      .wdata (bank_wdata[8*g +: 8]),
      .rdata (bank_rdata[g])
    );
  end

  logic       ld_q, sgn_q;
  logic [1:0] off_q;
  memlen_e    len_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ld_q       <= 1'b0;
      sgn_q      <= 1'b0;
      off_q      <= 2'b00;
      len_q      <= LEN_NONE;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept & err;
      ld_q       <= ok & ~req_we;
      if (ok && !req_we) begin
        sgn_q <= req_signed;
        off_q <= off;
        len_q <= len;
      end
    end
  end

  logic [31:0] rd_word, rd_shift;

  assign rd_word    = {bank_rdata[3], bank_rdata[2], bank_rdata[1], bank_rdata[0]};
  assign rd_shift   = rd_word >> {off_q, 3'b000};
  assign resp_rdata = ld_q ? extend(len_q, sgn_q, rd_shift) : 32'h0;

endmodule

// File: tb/tb_dmem_banked.sv
// Bench for dmem_banked (ADDR_WIDTH=6): directed cases plus random traffic
// checked against a byte-array reference memory.
module tb_dmem_banked;

  localparam int AW    = 6;
  localparam int BYTES = 2 ** AW;
  localparam int WORDS = BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_len;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [BYTES];

  dmem_banked #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_len    (req_len),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Reference: a flat byte array, little-endian, accessed with plain arithmetic.
  task automatic model(input logic we, input logic [1:0] len, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int n;
    n = (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : (len == 2'd3) ? 4 : 0;
    e = (n == 0) || (a >= BYTES) || ((a % n) != 0);
    d = 32'h0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) d = d | (32'(ref_mem[a + i]) << (8 * i));
        if (sgn && n < 4 && d[8*n - 1]) d = d | ~((32'd1 << (8 * n)) - 32'd1);
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Presents one request for one cycle and checks its response right after the edge.
  task automatic send(input logic we, input logic [1:0] len, input logic sgn,
                      input logic [31:0] a, input logic [31:0] wd, input string name,
                      output logic [31:0] got, output logic got_err);
    logic [31:0] exp_d;
    logic        exp_e;
    model(we, len, sgn, a, wd, exp_d, exp_e);
    req_valid  = 1'b1;
    req_we     = we;
    req_len    = len;
    req_signed = sgn;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== exp_e || resp_rdata !== exp_d) begin
      n_bad++;
      $display("FAIL %s addr=%h: got valid=%b err=%b data=%h, want valid=1 err=%b data=%h",
               name, a, resp_valid, resp_err, resp_rdata, exp_e, exp_d);
    end
    got     = resp_rdata;
    got_err = resp_err;
  endtask

  task automatic idle(input string name);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    @(posedge clk);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL %s: got valid=%b data=%h, want valid=0 data=0", name, resp_valid, resp_rdata);
    end
  endtask

  // Releases reset and counts edges until req_ready rises; a pending load is
  // held throughout and must not be answered while the sweep runs.
  task automatic release_and_count(input string name);
    int cyc = 0;
    int early = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_len   = 2'd3;
    req_addr  = 32'h0;
    rst       = 1'b1;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid !== 1'b0) early++;
      if (req_ready === 1'b1) break;
    end
    req_valid = 1'b0;
    clear_model();
    n_cmp++;
    if (cyc != WORDS || early != 0) begin
      n_bad++;
      $display("FAIL %s: ready after %0d cycles with %0d early responses, want %0d and 0",
               name, cyc, early, WORDS);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_len   = 2'd0;
    req_signed = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b data=%h, want all 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    release_and_count("reset_sweep_len");
    send(1'b0, 2'd3, 1'b0, 32'h0C, 32'h0, "load_after_sweep", d, e);
  endtask

  task automatic test_directed();
    logic [31:0] d;
    logic        e;
    send(1'b1, 2'd3, 1'b0, 32'h10, 32'h8899AABB, "st_word_10", d, e);
    send(1'b1, 2'd1, 1'b0, 32'h11, 32'hDEADBE7F, "st_byte_11", d, e);
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "ld_word_10", d, e);
    n_cmp++;
    if (d !== 32'h88997FBB) begin
      n_bad++;
      $display("FAIL merged_word: got %h want 88997fbb", d);
    end
    send(1'b0, 2'd2, 1'b1, 32'h12, 32'h0, "ld_half_s", d, e);
    n_cmp++;
    if (d !== 32'hFFFF8899) begin
      n_bad++;
      $display("FAIL half_signed: got %h want ffff8899", d);
    end
    send(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, "ld_half_u", d, e);
    n_cmp++;
    if (d !== 32'h00008899) begin
      n_bad++;
      $display("FAIL half_unsigned: got %h want 00008899", d);
    end
    send(1'b1, 2'd1, 1'b0, 32'h16, 32'h00000080, "st_byte_80", d, e);
    send(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, "ld_byte_s", d, e);
    n_cmp++;
    if (d !== 32'hFFFFFF80) begin
      n_bad++;
      $display("FAIL byte_signed: got %h want ffffff80", d);
    end
    send(1'b1, 2'd3, 1'b0, 32'h13, 32'h11223344, "st_word_misal", d, e);
    n_cmp++;
    if (e !== 1'b1 || d !== 32'h0) begin
      n_bad++;
      $display("FAIL misaligned_store: got err=%b data=%h want err=1 data=0", e, d);
    end
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "unchanged_10", d, e);
    n_cmp++;
    if (d !== 32'h88997FBB) begin
      n_bad++;
      $display("FAIL unchanged_after_err: got %h want 88997fbb", d);
    end
    send(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, "ld_out_of_range", d, e);
    n_cmp++;
    if (e !== 1'b1) begin
      n_bad++;
      $display("FAIL out_of_range: got err=%b want 1", e);
    end
    send(1'b0, 2'd0, 1'b0, 32'h04, 32'h0, "ld_len_none", d, e);
    send(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, "ld_half_misal", d, e);
    idle("idle_after_directed");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e;
    send(1'b1, 2'd3, 1'b0, 32'h20, 32'h12345678, "b2b_store", d, e);
    send(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, "b2b_load", d, e);
    n_cmp++;
    if (d !== 32'h12345678) begin
      n_bad++;
      $display("FAIL store_then_load: got %h want 12345678", d);
    end
    for (int i = 0; i < 4; i++)
      send(1'b0, 2'd1, 1'($urandom), 32'h20 + 32'(i), 32'h0, "b2b_bytes", d, e);
    idle("idle_after_b2b");
  endtask

  task automatic test_random();
    logic [31:0] d, a;
    logic        e;
    logic [1:0]  len;
    for (int i = 0; i < 400; i++) begin
      len = 2'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 9) < 7) a = a & ~32'(len == 2'd3 ? 3 : len == 2'd2 ? 1 : 0);
      if ($urandom_range(0, 19) == 0) a = $urandom | 32'(BYTES);
      if ($urandom_range(0, 9) == 0) idle("rand_idle");
      send(1'($urandom), len, 1'($urandom), a, $urandom, "rand", d, e);
    end
    idle("idle_after_random");
  endtask

  task automatic test_reset_midway();
    logic [31:0] d;
    logic        e;
    // Reset in the response cycle of a load: outputs must clear immediately.
    send(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, "pre_reset_load", d, e);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_load: valid=%b data=%h ready=%b, want 0 0 0",
               resp_valid, resp_rdata, req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    release_and_count("reset_mid_sweep_len");
    send(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, "zero_after_resweep", d, e);
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "zero_after_resweep", d, e);
    idle("idle_final");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised, handshaked successor of the single-cycle data memory. Byte-addressed, 32-bit data path with four byte-lane banks, synchronous read (1-cycle latency), true byte/half/word stores, signed/unsigned load extension, misalignment and range error reporting, and a post-reset zero-fill sweep. Sits in the MEM stage behind the pipeline's load/store unit. The core issues at most one request per cycle and always accepts responses.

## Interface
- `ADDR_WIDTH`, default 12: byte-address width. Memory is 2^ADDR_WIDTH bytes, WORDS = 2^(ADDR_WIDTH-2).
- `INIT_ZERO`, default 1: when 1, clear all words after reset. When 0, go ready immediately with contents undefined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_len` in 2: access size, using the shared memlen encoding.
- `req_signed` in 1: sign-extend load result. Ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response for the request accepted in the previous cycle.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_err` out 1: request was misaligned, out of range, or had an illegal length.

## Operation
- FSM states:
  - INIT:
    - `req_ready` = 0.
    - Counter `cnt` (ADDR_WIDTH-2 bits) writes 0 to all four banks at word `cnt` each cycle.
    - At `cnt` = WORDS-1, go to RUN.
  - RUN:
    - `req_ready` = 1.
    - No exit except reset.
- Reset asserted, at any time including mid-sweep:
  - state ← INIT (or RUN if `INIT_ZERO`=0), `cnt` ← 0.
  - `resp_valid`, `resp_err` ← 0. Response data registers ← 0, so `resp_rdata` = 0.
  - The sweep restarts from word 0.
- Error conditions (checked at acceptance):
  - `req_len` = none.
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr[31:ADDR_WIDTH]`≠0.
- On error: no bank write, `resp_err`=1, `resp_rdata`=0.
- Store with no error:
  - Lane enables are byte: 1 at `addr[1:0]`; half: 2'b11 shifted by `{addr[1],1'b0}`; word: all.
  - Write data is replicated into the selected lanes. Unselected bytes are unchanged.
- Load with no error:
  - All banks are read at word `addr[ADDR_WIDTH-1:2]`.
  - `addr[1:0]`, `req_len` and `req_signed` are registered.
  - The selected byte/half is shifted to bit 0, then sign- or zero-extended.
- Every accepted request, load, store or error, produces exactly one `resp_valid` pulse.

## Timing
- Accept in cycle N; `resp_valid`/`resp_rdata`/`resp_err` are valid in cycle N+1 for one cycle only.
- Back-to-back requests are accepted every cycle. Throughput is 1 per cycle.
- Store in cycle N followed by a load of the same word in cycle N+1 returns the new data. The write lands at edge N→N+1 and the read samples at edge N+1→N+2.
- `req_ready` first rises WORDS cycles after reset deasserts (INIT_ZERO=1), or in the cycle after deassertion (INIT_ZERO=0).
- A request presented while `req_ready`=0 is ignored. The requester holds it until accepted.
- Bank read output is not a combinational path from `req_*`. `resp_rdata` is combinational only from registered state.

## Structure
- Shared macro/package entries:
  - Memlen encoding: none=2'b00, byte=2'b01, half=2'b10, word=2'b11.
  - FSM state encodings INIT/RUN.
- Sub-module `dmem_bank`:
  - One byte lane with parameter depth.
  - Synchronous write with enable; synchronous registered read output with async clear.
  - Four instances.
- Top level holds the FSM, sweep counter, decode/error logic, response registers and the extraction mux.

## Test plan
- Reset with `ADDR_WIDTH`=6 → `req_ready`=0 for exactly 16 cycles, then 1. A load of word 0xC returns 0 with `resp_err`=0.
- Word store 0x8899AABB @0x10, then byte store 0x7F @0x11 → word load @0x10 returns 0x88997FBB.
- Half loads @0x12:
  - Signed load returns 0xFFFF8899.
  - Unsigned load returns 0x00008899.
  - Signed byte load of 0x80 returns 0xFFFFFF80.
- Misaligned and out-of-range requests:
  - Word store @0x13 → `resp_err`=1, `resp_rdata`=0, and memory is unchanged (verified by a later read).
  - Load @0x100 (ADDR_WIDTH=6) → `resp_err`=1.
- Store 0x12345678 @0x20 in cycle N, load @0x20 in N+1 → 0x12345678 in N+2. Four consecutive loads produce four consecutive `resp_valid` cycles.
- Assert `rst` mid-sweep and mid-load → `resp_valid` drops immediately, the sweep restarts, and `req_ready` stays 0 for the full WORDS cycles afterwards.
